// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 16-bit ALU and its users.
//   alu_op_t    - ALU select encoding (110/111 fall through to "pass A").
//   ALU_DATA_W  - operand/result width of the alu instance.
//   arb_state_t - alu_arbiter FSM states.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_NOT,
        OP_CLR
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
// Ports:
//   req     in  N     - request vector
//   ptr     in  IdxW  - index where the search starts (highest priority)
//   gnt     out N     - one-hot grant, zero when no request
//   gnt_idx out IdxW  - binary index of the grant, 0 when no request
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx
);

    logic            found;
    logic [IdxW-1:0] sel;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sel     = '0;
        // Walk ptr, ptr+1, ... wrapping at N; first asserted request wins.
        for (int unsigned i = 0; i < N; i++) begin
            sel = IdxW'((32'(ptr) + i) % N);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between NUM_REQ requesters.
// Round-robin grant in IDLE latches the winner's operands/opcode into registers that drive
// the alu; the result is captured in EXEC and returned over a per-requester valid/ready
// response channel in RESP.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - per-requester request handshake (ready one-hot or zero)
//   req_a/req_b/req_op    - packed per-requester payload (DATA_W, DATA_W, 3 bits each)
//   req_lock              - hold grant for the next operation (lock build only)
//   rsp_valid/rsp_ready   - per-requester response handshake (valid one-hot or zero)
//   rsp_data              - shared result, qualified by rsp_valid
//   alu_a/alu_b/alu_sel   - registered alu inputs
//   alu_out               - alu result
// Build option: define ALU_ARB_LOCK_EN to enable grant locking via req_lock.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = ALU_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]      req_op,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [2:0]                alu_sel,
    input  logic [DATA_W-1:0]         alu_out
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    arb_state_t          state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]          alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]  req_mask;
    logic [NUM_REQ-1:0]  gnt;
    logic [IdxW-1:0]     gnt_idx;
    logic [IdxW-1:0]     owner_next;

    assign owner_next = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);

`ifdef ALU_ARB_LOCK_EN
    logic locked_q, locked_d;

    // While locked only the owner may compete; rr_ptr already points at it.
    assign req_mask = locked_q ? (req_valid & (NUM_REQ'(1) << owner_q)) : req_valid;
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign req_mask    = req_valid;
`endif

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_mask),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        rsp_valid  = '0;
`ifdef ALU_ARB_LOCK_EN
        locked_d   = locked_q;
`endif
        unique case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (|req_mask) begin
                    alu_a_d   = req_a[gnt_idx*DATA_W +: DATA_W];
                    alu_b_d   = req_b[gnt_idx*DATA_W +: DATA_W];
                    alu_sel_d = req_op[gnt_idx*3 +: 3];
                    owner_d   = gnt_idx;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_out;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = NUM_REQ'(1) << owner_q;
                if (rsp_ready[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_next;
`ifdef ALU_ARB_LOCK_EN
                    locked_d = req_lock[owner_q];
                    if (req_lock[owner_q]) begin
                        rr_ptr_d = owner_q;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rsp_data_q <= '0;
`ifdef ALU_ARB_LOCK_EN
            locked_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rsp_data_q <= rsp_data_d;
`ifdef ALU_ARB_LOCK_EN
            locked_q   <= locked_d;
`endif
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural alu model.
module tb_alu_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*3-1:0]   req_op;
    logic [N-1:0]     req_lock;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [2:0]       alu_sel;
    logic [W-1:0]     alu_out;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out)
    );

    // Reference alu
    always_comb begin
        alu_out = alu_a;
        case (alu_sel)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a & alu_b;
            3'b011:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = ~alu_a;
            3'b101:  alu_out = '0;
            default: alu_out = alu_a;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*3 +: 3] = op;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_lock  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Single operation; entered and left at posedge+1.
    task automatic do_op(input string tag, input int i, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] op, input logic [15:0] exp);
        logic seen;
        seen = 1'b0;
        set_req(i, a, b, op);
        req_valid[i] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_ready"}, 32'(req_ready), 32'(1) << i);
        if (!seen) begin
            req_valid = '0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        @(negedge clk);
        check({tag, "_exec_ready"}, 32'(req_ready), 0);
        check({tag, "_exec_rsp"}, 32'(rsp_valid), 0);
        check({tag, "_alu_sel"}, 32'(alu_sel), 32'(op));
        check({tag, "_alu_a"}, 32'(alu_a), 32'(a));
        check({tag, "_alu_b"}, 32'(alu_b), 32'(b));
        @(negedge clk);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1) << i);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp));
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[i] = 1'b0;
    endtask

    int g_cnt;
    int r_cnt;
    int last_g;
    int last_r;
    int exp_lock [4];
    logic seen_g;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_lock  = '0;
        rsp_ready = '0;

        // Reset values
        #12;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_b", 32'(alu_b), 0);
        check("rst_alu_sel", 32'(alu_sel), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request and opcode coverage
        do_op("single", 2, 16'h1234, 16'h0F0F, 3'b000, 16'h2143);
        do_op("sub_wrap", 0, 16'h0000, 16'h0001, 3'b001, 16'hFFFF);
        do_op("add_wrap", 1, 16'hFFFF, 16'h0002, 3'b000, 16'h0001);
        do_op("not", 3, 16'h00FF, 16'h0000, 3'b100, 16'hFF00);
        do_op("clr", 2, 16'h1234, 16'h5678, 3'b101, 16'h0000);
        do_op("op111", 0, 16'hBEEF, 16'h1111, 3'b111, 16'hBEEF);
        do_op("and", 1, 16'hF0F0, 16'h3C3C, 3'b010, 16'h3030);

        // Fairness: all valid, rsp_ready high
        apply_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 16'(16'h0100 * (i + 1)), 16'(i), 3'b000);
        end
        req_valid = '1;
        rsp_ready = '1;
        g_cnt = 0;
        r_cnt = 0;
        last_g = 0;
        last_r = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (req_ready != '0 && g_cnt < 5) begin
                check("fair_gnt", 32'(req_ready), 32'(1) << (g_cnt % N));
                if (g_cnt > 0) check("fair_gnt_gap", 32'(cyc - last_g), 3);
                last_g = cyc;
                g_cnt++;
            end
            if (rsp_valid != '0 && r_cnt < 4) begin
                check("fair_rsp_owner", 32'(rsp_valid), 32'(1) << r_cnt);
                check("fair_rsp_data", 32'(rsp_data), 32'(16'h0100 * (r_cnt + 1) + r_cnt));
                if (r_cnt > 0) check("fair_rsp_gap", 32'(cyc - last_r), 3);
                last_r = cyc;
                r_cnt++;
            end
        end
        check("fair_gnt_count", 32'(g_cnt), 5);
        check("fair_rsp_count", 32'(r_cnt), 4);
        apply_reset();

        // Backpressure: requester 1 stalls in RESP while requester 0 waits
        set_req(1, 16'h00F0, 16'h0F00, 3'b011);
        set_req(0, 16'h0003, 16'h0004, 3'b000);
        req_valid = 4'b0010;
        seen_g = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                seen_g = 1'b1;
                break;
            end
        end
        check("bp_gnt1", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid = 4'b0001;
        rsp_ready = 4'b1101;
        @(negedge clk);
        check("bp_exec_ready", 32'(req_ready), 0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'h2);
            check("bp_rsp_data", 32'(rsp_data), 32'h0FF0);
            check("bp_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 4'b0010;
        @(negedge clk);
        check("bp_release_valid", 32'(rsp_valid), 32'h2);
        @(negedge clk);
        check("bp_gnt0", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        check("bp_rsp0_valid", 32'(rsp_valid), 32'h1);
        check("bp_rsp0_data", 32'(rsp_data), 32'h7);
        @(posedge clk);
        #1 rsp_ready = '0;

        // Reset during EXEC
        set_req(3, 16'h0005, 16'h0003, 3'b001);
        req_valid = 4'b1000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready[3]) break;
        end
        check("rst_mid_gnt3", 32'(req_ready), 32'h8);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("rst_mid_exec_a", 32'(alu_a), 32'h5);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_req_ready", 32'(req_ready), 0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        check("rst_mid_rsp_data", 32'(rsp_data), 0);
        check("rst_mid_alu_a", 32'(alu_a), 0);
        check("rst_mid_alu_b", 32'(alu_b), 0);
        check("rst_mid_alu_sel", 32'(alu_sel), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_mid_no_stale", 32'(rsp_valid), 0);
        end
        @(posedge clk);
        #1 req_valid = 4'b1001;
        @(negedge clk);
        check("rst_mid_first_gnt", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1 rsp_ready = '0;

        // Lock: bring rr_ptr to 3, then requester 3 asks for lock with all others valid
        do_op("lock_pre", 2, 16'h0001, 16'h0001, 3'b000, 16'h0002);
`ifdef ALU_ARB_LOCK_EN
        exp_lock = '{3, 3, 3, 0};
`else
        exp_lock = '{3, 0, 1, 2};
`endif
        req_valid = '1;
        rsp_ready = '1;
        req_lock  = 4'b1000;
        g_cnt = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (req_ready != '0 && g_cnt < 4) begin
                check("lock_gnt", 32'(req_ready), 32'(1) << exp_lock[g_cnt]);
                g_cnt++;
                if (g_cnt == 3) req_lock = '0;
            end
        end
        check("lock_gnt_count", 32'(g_cnt), 4);
        req_valid = '0;
        rsp_ready = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
